// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared encodings and default constants for the fetch-stage sequencer.
// Imported by the PC selector and by the sequencer top.
package fetch_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RST = 2'd0,
    ST_RUN = 2'd1,
    ST_IMM = 2'd2
  } state_e;

  // Source of the next PC value.
  typedef enum logic [2:0] {
    SEL_SEQ = 3'd0,
    SEL_JMP = 3'd1,
    SEL_POP = 3'd2,
    SEL_INT = 3'd3,
    SEL_VEC = 3'd4
  } sel_e;

  localparam int unsigned DEF_AW         = 32;
  localparam logic [3:0]  DEF_IMM_OPCODE = 4'd8;
  localparam int unsigned DEF_RST_VEC    = 32;
  localparam int unsigned DEF_INT_VEC    = 0;

endpackage

// File: rtl/fetch_seq_ctrl_pc_mux.sv
// Combinational next-PC selector: sequential PC+1 (wrapping), jump target,
// popped PC, interrupt vector or reset/exception vector.
module fetch_pc_mux
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int unsigned   AW      = DEF_AW,
  parameter logic [AW-1:0] RST_VEC = AW'(DEF_RST_VEC),
  parameter logic [AW-1:0] INT_VEC = AW'(DEF_INT_VEC)
) (
  input  sel_e          sel,
  input  logic [AW-1:0] pc_cur,
  input  logic [AW-1:0] jmp_value,
  input  logic [AW-1:0] pop_value,
  output logic [AW-1:0] pc_next
);

  logic [AW-1:0] pc_inc;

  // Truncating add: the all-ones PC wraps to zero.
  assign pc_inc = pc_cur + {{(AW-1){1'b0}}, 1'b1};

  always_comb begin
    pc_next = pc_inc;
    case (sel)
      SEL_SEQ: pc_next = pc_inc;
      SEL_JMP: pc_next = jmp_value;
      SEL_POP: pc_next = pop_value;
      SEL_INT: pc_next = INT_VEC;
      SEL_VEC: pc_next = RST_VEC;
      default: pc_next = pc_inc;
    endcase
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch-stage sequencer: picks the next PC source and write enable each cycle,
// tracks two-word I-type fetches and defers interrupt entry to a safe point.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int unsigned   AW         = DEF_AW,
  parameter logic [3:0]    IMM_OPCODE = DEF_IMM_OPCODE,
  parameter logic [AW-1:0] RST_VEC    = AW'(DEF_RST_VEC),
  parameter logic [AW-1:0] INT_VEC    = AW'(DEF_INT_VEC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc_cur,
  input  logic [3:0]    opcode,
  input  logic          stall,
  input  logic          exception,
  input  logic          interrupt,
  input  logic          set_int,
  input  logic          pop_pc,
  input  logic [AW-1:0] pop_value,
  input  logic          jmp_req,
  input  logic [AW-1:0] jmp_value,
  output logic [AW-1:0] pc_next,
  output logic          pc_en,
  output logic          squash,
  output logic          imm_phase,
  output logic          int_ack,
  output logic          int_pending,
  output logic [1:0]    state_dbg
);

  // Handshake: there is no backpressure on the PC register. pc_next is
  // meaningful only while pc_en=1; the register loads it on the falling edge.

  state_e state_q, state_d;
  logic   pending_q, pending_d;
  sel_e   sel;
  logic   pc_en_c, squash_c, int_ack_c;

  always_comb begin
    state_d   = state_q;
    sel       = SEL_SEQ;
    pc_en_c   = 1'b1;
    squash_c  = 1'b0;
    int_ack_c = 1'b0;
    if (state_q == ST_RST) begin
      sel      = SEL_VEC;
      squash_c = 1'b1;
      state_d  = ST_RUN;
    end else if (exception) begin
      sel      = SEL_VEC;
      squash_c = 1'b1;
      state_d  = ST_RUN;
    end else if (pop_pc) begin
      sel      = SEL_POP;
      squash_c = 1'b1;
      state_d  = ST_RUN;
    end else if (jmp_req) begin
      sel      = SEL_JMP;
      squash_c = 1'b1;
      state_d  = ST_RUN;
    end else if (pending_q && (state_q == ST_RUN) && !stall) begin
      sel       = SEL_INT;
      squash_c  = 1'b1;
      int_ack_c = 1'b1;
      state_d   = ST_RUN;
    end else if (stall) begin
      pc_en_c = 1'b0;
    end else if (state_q == ST_IMM) begin
      // The immediate word must never reach decode as an instruction.
      squash_c = 1'b1;
      state_d  = ST_RUN;
    end else if (opcode == IMM_OPCODE) begin
      state_d = ST_IMM;
    end
  end

  // A request arriving in the ack cycle re-arms the latch.
  assign pending_d = (pending_q & ~int_ack_c) | interrupt | set_int;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RST;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

  fetch_pc_mux #(
    .AW      (AW),
    .RST_VEC (RST_VEC),
    .INT_VEC (INT_VEC)
  ) u_pc_mux (
    .sel       (sel),
    .pc_cur    (pc_cur),
    .jmp_value (jmp_value),
    .pop_value (pop_value),
    .pc_next   (pc_next)
  );

  assign pc_en       = pc_en_c;
  assign squash      = squash_c;
  assign int_ack     = int_ack_c;
  assign imm_phase   = (state_q == ST_IMM);
  assign int_pending = pending_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Self-checking bench for fetch_seq_ctrl: directed scenarios plus random
// traffic, checked against a behavioural model that also plays the PC register.
module tb_fetch_seq_ctrl;

  localparam int AW = 32;
  localparam logic [AW-1:0] M_RST_VEC = 32'd32;
  localparam logic [AW-1:0] M_INT_VEC = 32'd0;

  logic          clk;
  logic          reset;
  logic [AW-1:0] pc_cur;
  logic [3:0]    opcode;
  logic          stall, exception, interrupt, set_int, pop_pc, jmp_req;
  logic [AW-1:0] pop_value, jmp_value;
  logic [AW-1:0] pc_next;
  logic          pc_en, squash, imm_phase, int_ack, int_pending;
  logic [1:0]    state_dbg;

  fetch_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .pc_cur      (pc_cur),
    .opcode      (opcode),
    .stall       (stall),
    .exception   (exception),
    .interrupt   (interrupt),
    .set_int     (set_int),
    .pop_pc      (pop_pc),
    .pop_value   (pop_value),
    .jmp_req     (jmp_req),
    .jmp_value   (jmp_value),
    .pc_next     (pc_next),
    .pc_en       (pc_en),
    .squash      (squash),
    .imm_phase   (imm_phase),
    .int_ack     (int_ack),
    .int_pending (int_pending),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [AW-1:0] exp_q[$];

  // Model: PC register plus three flags describing where the fetch stream is.
  logic [AW-1:0] pc_reg;
  bit m_after_reset;   // next edge loads the reset vector unconditionally
  bit m_in_imm;        // word now being fetched is an immediate
  bit m_pend;          // interrupt request latched, not yet serviced

  logic [AW-1:0] last_pc_next;
  logic last_pc_en, last_squash, last_imm, last_ack, last_pend;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk);
    reset = 1'b1;
    #1;
    m_after_reset = 1'b1;
    m_in_imm = 1'b0;
    m_pend = 1'b0;
    check("rst_pc_next", pc_next, M_RST_VEC);
    check("rst_pc_en", {31'd0, pc_en}, 32'd1);
    check("rst_squash", {31'd0, squash}, 32'd1);
    check("rst_imm", {31'd0, imm_phase}, 32'd0);
    check("rst_ack", {31'd0, int_ack}, 32'd0);
    check("rst_pend", {31'd0, int_pending}, 32'd0);
    @(negedge clk);
  endtask

  task automatic step(input bit exc, input bit intr, input bit sint, input bit pop,
                      input bit jmp, input bit stl, input logic [3:0] opc,
                      input logic [AW-1:0] popv, input logic [AW-1:0] jmpv);
    logic [AW-1:0] e_next;
    bit e_en, e_sq, e_imm, e_ack, n_imm, n_pend;
    @(posedge clk);
    reset = 1'b0;
    exception = exc; interrupt = intr; set_int = sint;
    pop_pc = pop; jmp_req = jmp; stall = stl; opcode = opc;
    pop_value = popv; jmp_value = jmpv; pc_cur = pc_reg;
    #1;
    e_next = pc_reg + 32'd1;
    e_en = 1'b1; e_sq = 1'b0; e_imm = m_in_imm; e_ack = 1'b0; n_imm = m_in_imm;
    if (m_after_reset) begin
      e_next = M_RST_VEC; e_sq = 1'b1; e_imm = 1'b0; n_imm = 1'b0;
    end else if (exc) begin
      e_next = M_RST_VEC; e_sq = 1'b1; n_imm = 1'b0;
    end else if (pop) begin
      e_next = popv; e_sq = 1'b1; n_imm = 1'b0;
    end else if (jmp) begin
      e_next = jmpv; e_sq = 1'b1; n_imm = 1'b0;
    end else if (m_pend && !m_in_imm && !stl) begin
      e_next = M_INT_VEC; e_sq = 1'b1; e_ack = 1'b1; n_imm = 1'b0;
    end else if (stl) begin
      e_en = 1'b0;
    end else if (m_in_imm) begin
      e_sq = 1'b1; n_imm = 1'b0;
    end else begin
      n_imm = (opc == 4'd8);
    end
    n_pend = (m_pend && !e_ack) || intr || sint;

    if (e_en) exp_q.push_back(e_next);
    if (e_en && exp_q.size() > 0) check("pc_next", pc_next, exp_q.pop_front());
    check("pc_en", {31'd0, pc_en}, {31'd0, e_en});
    check("squash", {31'd0, squash}, {31'd0, e_sq});
    check("imm_phase", {31'd0, imm_phase}, {31'd0, e_imm});
    check("int_ack", {31'd0, int_ack}, {31'd0, e_ack});
    check("int_pending", {31'd0, int_pending}, {31'd0, m_pend});
    last_pc_next = pc_next; last_pc_en = pc_en; last_squash = squash;
    last_imm = imm_phase; last_ack = int_ack; last_pend = int_pending;

    @(negedge clk);
    m_after_reset = 1'b0;
    m_in_imm = n_imm;
    m_pend = n_pend;
    if (e_en) pc_reg = e_next;
  endtask

  task automatic idle(input logic [3:0] opc);
    step(0, 0, 0, 0, 0, 0, opc, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; exception = 0; interrupt = 0; set_int = 0; pop_pc = 0;
    jmp_req = 0; stall = 0; opcode = 4'd0; pop_value = '0; jmp_value = '0;
    pc_cur = '0; pc_reg = '0;
    m_after_reset = 1'b1; m_in_imm = 1'b0; m_pend = 1'b0;

    do_reset();
    idle(4'd0);
    check("boot_vec", last_pc_next, 32'd32);

    // Reset pulse while an immediate is being fetched.
    idle(4'd8);
    idle(4'd0);
    check("pre_rst_imm", {31'd0, last_imm}, 32'd1);
    step(0, 1, 0, 0, 0, 0, 4'd0, '0, '0);
    do_reset();
    idle(4'd0);
    check("rel_pc_next", last_pc_next, 32'd32);
    check("rel_pc_en", {31'd0, last_pc_en}, 32'd1);
    idle(4'd0);
    check("rel_imm", {31'd0, last_imm}, 32'd0);
    check("rel_pend", {31'd0, last_pend}, 32'd0);

    // Two-word I-type fetch.
    pc_reg = 32'd40;
    idle(4'd8);
    idle(4'd0);
    check("imm_pc", last_pc_next, 32'd42);
    check("imm_sq", {31'd0, last_squash}, 32'd1);
    idle(4'd0);
    check("imm_drop", {31'd0, last_imm}, 32'd0);

    // Interrupt raised while the opcode word is fetched: deferred past IMM.
    step(0, 1, 0, 0, 0, 0, 4'd8, '0, '0);
    idle(4'd0);
    check("defer_ack", {31'd0, last_ack}, 32'd0);
    check("defer_pend", {31'd0, last_pend}, 32'd1);
    idle(4'd0);
    check("int_ack", {31'd0, last_ack}, 32'd1);
    check("int_vec", last_pc_next, 32'd0);
    idle(4'd0);
    check("int_clr", {31'd0, last_pend}, 32'd0);

    // Stall holds off a pending interrupt; a jump still redirects.
    step(0, 1, 0, 0, 0, 0, 4'd0, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 4'd0, '0, '0);
    step(0, 0, 0, 0, 1, 1, 4'd0, '0, 32'h100);
    check("stall_jmp", last_pc_next, 32'h100);
    idle(4'd0);

    // Exception beats a simultaneous interrupt.
    step(1, 1, 0, 0, 0, 0, 4'd0, '0, '0);
    check("exc_vec", last_pc_next, 32'd32);
    idle(4'd0);
    check("exc_then_int", last_pc_next, 32'd0);
    check("exc_then_ack", {31'd0, last_ack}, 32'd1);

    // Pop beats jump; sequential wrap.
    step(0, 0, 0, 1, 1, 0, 4'd0, 32'h55, 32'h99);
    check("pop_win", last_pc_next, 32'h55);
    pc_reg = 32'hFFFF_FFFF;
    idle(4'd0);
    check("wrap", last_pc_next, 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] opc;
      opc = ($urandom_range(0, 2) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) pc_reg = 32'hFFFF_FFFF;
      if ($urandom_range(0, 120) == 0) do_reset();
      step($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, opc,
           $urandom, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
